// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_if
// Brief    : Dispatch, CDB and issue bundle between dispatcher/ROB, RS and ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rs_if #(
    parameter int TAG_W  = 4,
    parameter int OP_W   = 5,
    parameter int DATA_W = 32
) ();
    logic              disp_valid;
    logic [OP_W-1:0]   disp_op;
    logic              disp_qj_busy;
    logic              disp_qk_busy;
    logic [TAG_W-1:0]  disp_qj;
    logic [TAG_W-1:0]  disp_qk;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic [DATA_W-1:0] disp_pc;
    logic [DATA_W-1:0] disp_imm;
    logic [TAG_W-1:0]  disp_dest;

    logic              cdb0_valid;
    logic [TAG_W-1:0]  cdb0_tag;
    logic [DATA_W-1:0] cdb0_value;
    logic              cdb1_valid;
    logic [TAG_W-1:0]  cdb1_tag;
    logic [DATA_W-1:0] cdb1_value;

    logic              rs_full;
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_rs1;
    logic [DATA_W-1:0] issue_rs2;
    logic [DATA_W-1:0] issue_pc;
    logic [DATA_W-1:0] issue_imm;
    logic [TAG_W-1:0]  issue_dest;

    modport master (
        output disp_valid, disp_op, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
               disp_vj, disp_vk, disp_pc, disp_imm, disp_dest,
               cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
        input  rs_full, issue_valid, issue_op, issue_rs1, issue_rs2, issue_pc,
               issue_imm, issue_dest
    );

    modport slave (
        input  disp_valid, disp_op, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
               disp_vj, disp_vk, disp_pc, disp_imm, disp_dest,
               cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
        output rs_full, issue_valid, issue_op, issue_rs1, issue_rs2, issue_pc,
               issue_imm, issue_dest
    );
endinterface
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Brief    : ALU reservation station with dual-CDB wakeup and in-order-by-index
//            single issue per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 5,
    parameter int DATA_W  = 32
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic rdy_in,
    input  wire logic flush_in,
    alu_rs_if.slave   bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_busy;
    logic [RS_SIZE-1:0] r_qk_busy;
    logic [OP_W-1:0]    r_op   [RS_SIZE];
    logic [DATA_W-1:0]  r_vj   [RS_SIZE];
    logic [DATA_W-1:0]  r_vk   [RS_SIZE];
    logic [TAG_W-1:0]   r_qj   [RS_SIZE];
    logic [TAG_W-1:0]   r_qk   [RS_SIZE];
    logic [DATA_W-1:0]  r_pc   [RS_SIZE];
    logic [DATA_W-1:0]  r_imm  [RS_SIZE];
    logic [TAG_W-1:0]   r_dest [RS_SIZE];

    logic               r_issue_valid;
    logic [OP_W-1:0]    r_issue_op;
    logic [DATA_W-1:0]  r_issue_rs1;
    logic [DATA_W-1:0]  r_issue_rs2;
    logic [DATA_W-1:0]  r_issue_pc;
    logic [DATA_W-1:0]  r_issue_imm;
    logic [TAG_W-1:0]   r_issue_dest;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_full;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_valid;
    logic               w_disp_go;

    logic [RS_SIZE-1:0] w_j_wake;
    logic [RS_SIZE-1:0] w_k_wake;
    logic [DATA_W-1:0]  w_j_val [RS_SIZE];
    logic [DATA_W-1:0]  w_k_val [RS_SIZE];

    logic               w_dj_busy;
    logic               w_dk_busy;
    logic [DATA_W-1:0]  w_dj_val;
    logic [DATA_W-1:0]  w_dk_val;

    function automatic logic tag_hit(input logic valid, input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] tag);
        return valid && (cdb_tag == tag);
    endfunction

    assign w_ready   = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign w_full    = &r_busy;
    assign w_disp_go = bus.disp_valid && !w_full;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_alloc_idx = '0;
        w_sel_idx   = '0;
        w_sel_valid = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_alloc_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_sel_idx   = IDX_W'(i);
                w_sel_valid = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_wake
        logic w_j0, w_j1, w_k0, w_k1;
        assign w_j0 = tag_hit(bus.cdb0_valid, bus.cdb0_tag, r_qj[g]);
        assign w_j1 = tag_hit(bus.cdb1_valid, bus.cdb1_tag, r_qj[g]);
        assign w_k0 = tag_hit(bus.cdb0_valid, bus.cdb0_tag, r_qk[g]);
        assign w_k1 = tag_hit(bus.cdb1_valid, bus.cdb1_tag, r_qk[g]);

        assign w_j_wake[g] = r_busy[g] && r_qj_busy[g] && (w_j0 || w_j1);
        assign w_k_wake[g] = r_busy[g] && r_qk_busy[g] && (w_k0 || w_k1);
        // cdb0 takes priority if both buses ever carry the same tag
        assign w_j_val[g]  = w_j0 ? bus.cdb0_value : bus.cdb1_value;
        assign w_k_val[g]  = w_k0 ? bus.cdb0_value : bus.cdb1_value;
    end

    // Same-cycle bypass for operands arriving on a CDB as they are dispatched
    always_comb begin
        w_dj_busy = bus.disp_qj_busy;
        w_dj_val  = bus.disp_vj;
        if (bus.disp_qj_busy) begin
            if (tag_hit(bus.cdb0_valid, bus.cdb0_tag, bus.disp_qj)) begin
                w_dj_busy = 1'b0;
                w_dj_val  = bus.cdb0_value;
            end else if (tag_hit(bus.cdb1_valid, bus.cdb1_tag, bus.disp_qj)) begin
                w_dj_busy = 1'b0;
                w_dj_val  = bus.cdb1_value;
            end
        end
        w_dk_busy = bus.disp_qk_busy;
        w_dk_val  = bus.disp_vk;
        if (bus.disp_qk_busy) begin
            if (tag_hit(bus.cdb0_valid, bus.cdb0_tag, bus.disp_qk)) begin
                w_dk_busy = 1'b0;
                w_dk_val  = bus.cdb0_value;
            end else if (tag_hit(bus.cdb1_valid, bus.cdb1_tag, bus.disp_qk)) begin
                w_dk_busy = 1'b0;
                w_dk_val  = bus.cdb1_value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_pc[i]   <= '0;
                r_imm[i]  <= '0;
                r_dest[i] <= '0;
            end
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_rs1   <= '0;
            r_issue_rs2   <= '0;
            r_issue_pc    <= '0;
            r_issue_imm   <= '0;
            r_issue_dest  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy        <= '0;
                r_issue_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (w_j_wake[i]) begin
                        r_vj[i]      <= w_j_val[i];
                        r_qj_busy[i] <= 1'b0;
                    end
                    if (w_k_wake[i]) begin
                        r_vk[i]      <= w_k_val[i];
                        r_qk_busy[i] <= 1'b0;
                    end
                end

                r_issue_valid <= w_sel_valid;
                if (w_sel_valid) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_issue_op        <= r_op[w_sel_idx];
                    r_issue_rs1       <= r_vj[w_sel_idx];
                    r_issue_rs2       <= r_vk[w_sel_idx];
                    r_issue_pc        <= r_pc[w_sel_idx];
                    r_issue_imm       <= r_imm[w_sel_idx];
                    r_issue_dest      <= r_dest[w_sel_idx];
                end

                // The allocated slot is free, so it never collides with wakeup or select
                if (w_disp_go) begin
                    r_busy[w_alloc_idx]    <= 1'b1;
                    r_op[w_alloc_idx]      <= bus.disp_op;
                    r_qj_busy[w_alloc_idx] <= w_dj_busy;
                    r_qk_busy[w_alloc_idx] <= w_dk_busy;
                    r_qj[w_alloc_idx]      <= bus.disp_qj;
                    r_qk[w_alloc_idx]      <= bus.disp_qk;
                    r_vj[w_alloc_idx]      <= w_dj_val;
                    r_vk[w_alloc_idx]      <= w_dk_val;
                    r_pc[w_alloc_idx]      <= bus.disp_pc;
                    r_imm[w_alloc_idx]     <= bus.disp_imm;
                    r_dest[w_alloc_idx]    <= bus.disp_dest;
                end
            end
        end
    end

    assign bus.rs_full     = w_full;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_op    = r_issue_op;
    assign bus.issue_rs1   = r_issue_rs1;
    assign bus.issue_rs2   = r_issue_rs2;
    assign bus.issue_pc    = r_issue_pc;
    assign bus.issue_imm   = r_issue_imm;
    assign bus.issue_dest  = r_issue_dest;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Brief    : Self-checking bench for alu_rs against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs;
    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic rdy_in   = 1'b1;
    logic flush_in = 1'b0;
    bit   chk_en   = 1'b0;
    int   n_total  = 0;
    int   n_pass   = 0;

    alu_rs_if #(.TAG_W(4), .OP_W(5), .DATA_W(32)) bus ();

    alu_rs #(.RS_SIZE(8), .TAG_W(4), .OP_W(5), .DATA_W(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit        busy;
        bit [4:0]  op;
        bit [31:0] vj, vk, pc, imm;
        bit [3:0]  qj, qk, dest;
        bit        qjb, qkb;
    } ent_t;

    ent_t      m  [8];
    ent_t      nx [8];
    int        sel, fr;
    bit        e_valid;
    bit [4:0]  e_op;
    bit [31:0] e_rs1, e_rs2, e_pc, e_imm;
    bit [3:0]  e_dest;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Returns {still_pending, value} after snooping both CDBs
    function automatic bit [32:0] snoop(bit b, bit [3:0] q, bit [31:0] v);
        if (b && bus.cdb0_valid && bus.cdb0_tag == q) return {1'b0, bus.cdb0_value};
        if (b && bus.cdb1_valid && bus.cdb1_tag == q) return {1'b0, bus.cdb1_value};
        return {b, v};
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            e_valid = 0; e_op = 0; e_rs1 = 0; e_rs2 = 0; e_pc = 0; e_imm = 0; e_dest = 0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
                e_valid = 1'b0;
            end else begin
                nx = m; sel = -1; fr = -1;
                for (int i = 7; i >= 0; i--) begin
                    if (!m[i].busy) fr = i;
                    if (m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
                    if (m[i].busy) begin
                        {nx[i].qjb, nx[i].vj} = snoop(m[i].qjb, m[i].qj, m[i].vj);
                        {nx[i].qkb, nx[i].vk} = snoop(m[i].qkb, m[i].qk, m[i].vk);
                    end
                end
                e_valid = (sel >= 0);
                if (sel >= 0) begin
                    e_op = m[sel].op; e_rs1 = m[sel].vj; e_rs2 = m[sel].vk;
                    e_pc = m[sel].pc; e_imm = m[sel].imm; e_dest = m[sel].dest;
                    nx[sel].busy = 1'b0;
                end
                if (bus.disp_valid && fr >= 0) begin
                    nx[fr].busy = 1'b1;
                    nx[fr].op   = bus.disp_op;
                    nx[fr].qj   = bus.disp_qj;
                    nx[fr].qk   = bus.disp_qk;
                    nx[fr].pc   = bus.disp_pc;
                    nx[fr].imm  = bus.disp_imm;
                    nx[fr].dest = bus.disp_dest;
                    {nx[fr].qjb, nx[fr].vj} = snoop(bus.disp_qj_busy, bus.disp_qj, bus.disp_vj);
                    {nx[fr].qkb, nx[fr].vk} = snoop(bus.disp_qk_busy, bus.disp_qk, bus.disp_vk);
                end
                m = nx;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("rs_full",     bus.rs_full,     model_full());
            chk("issue_valid", bus.issue_valid, e_valid);
            chk("issue_op",    bus.issue_op,    e_op);
            chk("issue_rs1",   bus.issue_rs1,   e_rs1);
            chk("issue_rs2",   bus.issue_rs2,   e_rs2);
            chk("issue_pc",    bus.issue_pc,    e_pc);
            chk("issue_imm",   bus.issue_imm,   e_imm);
            chk("issue_dest",  bus.issue_dest,  e_dest);
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb0_valid = 1'b0;
        bus.cdb1_valid = 1'b0;
        flush_in       = 1'b0;
        rdy_in         = 1'b1;
    endtask

    task automatic disp(input bit [4:0] op, input bit qjb, input bit [3:0] qj, input bit [31:0] vj,
                        input bit qkb, input bit [3:0] qk, input bit [31:0] vk, input bit [3:0] dest);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_qj_busy = qjb;
        bus.disp_qj      = qj;
        bus.disp_vj      = vj;
        bus.disp_qk_busy = qkb;
        bus.disp_qk      = qk;
        bus.disp_vk      = vk;
        bus.disp_pc      = $urandom;
        bus.disp_imm     = $urandom;
        bus.disp_dest    = dest;
    endtask

    task automatic cdb(input bit which, input bit [3:0] tag, input bit [31:0] val);
        if (which == 1'b0) begin
            bus.cdb0_valid = 1'b1; bus.cdb0_tag = tag; bus.cdb0_value = val;
        end else begin
            bus.cdb1_valid = 1'b1; bus.cdb1_tag = tag; bus.cdb1_value = val;
        end
    endtask

    initial begin
        idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        bus.disp_valid = 1'b0;
        bus.cdb0_tag = 0; bus.cdb0_value = 0; bus.cdb1_tag = 0; bus.cdb1_value = 0;
        #2 rst_in = 1'b0;
        #1 chk_en = 1'b1;
        tick(); tick();
        chk("reset_valid", bus.issue_valid, 0);
        chk("reset_full",  bus.rs_full, 0);
        chk("reset_rs1",   bus.issue_rs1, 0);
        rst_in = 1'b1;

        // ADD, both ready: issue after the second edge
        disp(0, 0, 0, 5, 0, 0, 7, 3);
        tick(); idle();
        tick();
        chk("add_valid", bus.issue_valid, 1);
        chk("add_rs1",   bus.issue_rs1, 5);
        chk("add_rs2",   bus.issue_rs2, 7);
        chk("add_dest",  bus.issue_dest, 3);
        tick();
        chk("add_pulse", bus.issue_valid, 0);

        // SUB waiting on tag 6, woken by cdb1 two cycles later
        disp(1, 1, 6, 0, 0, 0, 3, 4);
        tick(); idle();
        tick();
        cdb(1, 6, 32'h10);
        tick(); idle();
        chk("sub_wait", bus.issue_valid, 0);
        tick();
        chk("sub_valid", bus.issue_valid, 1);
        chk("sub_rs1",   bus.issue_rs1, 32'h10);
        chk("sub_rs2",   bus.issue_rs2, 3);

        // Dispatch bypass from cdb0
        disp(2, 1, 2, 0, 0, 0, 1, 5);
        cdb(0, 2, 9);
        tick(); idle();
        chk("byp_wait", bus.issue_valid, 0);
        tick();
        chk("byp_valid", bus.issue_valid, 1);
        chk("byp_rs1",   bus.issue_rs1, 9);
        tick();

        // Fill all entries on tag 1, drop a ninth, then drain in index order
        for (int i = 0; i < 8; i++) begin
            disp(3, 1, 1, 0, 0, 0, i, i[3:0]);
            tick();
        end
        chk("fill_full", bus.rs_full, 1);
        disp(3, 1, 1, 0, 0, 0, 99, 15);
        tick(); idle();
        chk("fill_full2", bus.rs_full, 1);
        cdb(0, 1, 32'h77);
        tick(); idle();
        chk("fill_wake", bus.issue_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_valid", bus.issue_valid, 1);
            chk("drain_dest",  bus.issue_dest, i);
            chk("drain_rs1",   bus.issue_rs1, 32'h77);
            if (i == 0) chk("drain_full", bus.rs_full, 0);
        end
        tick();
        chk("drain_end", bus.issue_valid, 0);

        // Flush with a concurrent dispatch
        for (int i = 0; i < 3; i++) begin
            disp(4, 1, 4 + i, 0, 0, 0, 0, 8 + i);
            tick();
        end
        disp(5, 0, 0, 1, 0, 0, 2, 11);
        flush_in = 1'b1;
        tick(); idle();
        chk("flush_valid", bus.issue_valid, 0);
        chk("flush_full",  bus.rs_full, 0);
        cdb(0, 4, 1); cdb(1, 5, 2);
        tick(); idle();
        cdb(0, 6, 3);
        tick(); idle();
        tick();
        chk("flush_noissue", bus.issue_valid, 0);
        tick();
        chk("flush_noissue2", bus.issue_valid, 0);

        // Freeze with rdy_in low
        disp(6, 1, 9, 0, 0, 0, 4, 13);
        tick(); idle();
        rdy_in = 1'b0;
        disp(7, 0, 0, 1, 0, 0, 1, 12);
        cdb(0, 9, 32'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_valid", bus.issue_valid, 0);
            chk("frz_dest",  bus.issue_dest, 7);
        end
        idle();
        tick();
        chk("frz_resume", bus.issue_valid, 0);
        cdb(0, 9, 32'h55);
        tick(); idle();
        tick();
        chk("frz_issue", bus.issue_valid, 1);
        chk("frz_rs1",   bus.issue_rs1, 32'h55);
        chk("frz_dest2", bus.issue_dest, 13);

        // Randomized traffic with an asynchronous reset pulse mid-stream
        for (int it = 0; it < 3000; it++) begin
            idle();
            if ($urandom % 2 == 0)
                disp($urandom, ($urandom % 3) != 0, $urandom % 4, $urandom,
                     ($urandom % 3) != 0, $urandom % 4, $urandom, $urandom);
            if ($urandom % 3 == 0) cdb(0, $urandom % 4, $urandom);
            if ($urandom % 3 == 0) cdb(1, $urandom % 4, $urandom);
            flush_in = ($urandom % 40) == 0;
            rdy_in   = ($urandom % 8) != 0;
            if (it == 1503) rst_in = 1'b1;
            if (it == 1500) begin
                #2 rst_in = 1'b0;
            end
            tick();
        end
        idle();
        tick(); tick(); tick();
        chk("end_idle", bus.issue_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the integer ALU. It buffers decoded ALU instructions from dispatch and tracks pending source operands by ROB tag. It captures operand values broadcast on two common data buses (CDBs), and each cycle issues at most one ready instruction to the combinational ALU through registered issue outputs. It sits between the dispatcher/ROB and the ALU. It is cleared by branch-mispredict flush.

## Interface
- RS_SIZE, 8, number of entries (power of two, ≥2)
- TAG_W, 4, ROB tag width
- OP_W, 5, opcode width (`OP_TYPE`)
- DATA_W, 32, operand/PC/immediate width
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; 0 freezes all state
- flush_in  in  1  mispredict flush; clears every entry
- disp_valid  in  1  dispatch request
- disp_op  in  OP_W  opcode
- disp_qj_busy, disp_qk_busy  in  1 each  source operand pending
- disp_qj, disp_qk  in  TAG_W each  producer tags (valid when busy)
- disp_vj, disp_vk  in  DATA_W each  operand values (valid when not busy)
- disp_pc, disp_imm  in  DATA_W each  instruction PC, immediate
- disp_dest  in  TAG_W  destination ROB tag
- cdb0_valid, cdb1_valid  in  1 each  broadcast valid
- cdb0_tag, cdb1_tag  in  TAG_W each  broadcast tag
- cdb0_value, cdb1_value  in  DATA_W each  broadcast value
- rs_full  out  1  no free entry (combinational from state)
- issue_valid  out  1  issue bundle valid (registered)
- issue_op, issue_rs1, issue_rs2, issue_pc, issue_imm, issue_dest  out  as dispatch widths  registered issue bundle

## Operation
- Per entry: busy, op, vj, vk, qj, qk, qj_busy, qk_busy, pc, imm, dest.
- Free entries are computed from current state only. An entry freed by issue in cycle k is not reusable until cycle k+1.
- Dispatch: when disp_valid=1 and rs_full=0, write to the lowest-index free entry. Dispatch with rs_full=1 is illegal; the request is dropped and state is unchanged.
- Dispatch bypass: if a dispatched operand is busy and its tag matches a valid CDB in the same cycle, store the CDB value and clear the busy flag.
- Wakeup: for each busy entry, a valid CDB matching qj (qk) loads vj (vk) and clears qj_busy (qk_busy). Both operands may wake in one cycle, from either bus. If both buses carry the same tag (illegal), cdb0 wins.
- Ready = busy & ~qj_busy & ~qk_busy, evaluated on registered state. An operand woken in cycle k is ready in cycle k+1.
- Select: the lowest-index ready entry. On the edge, load the issue bundle (rs1=vj, rs2=vk), set issue_valid=1, and clear the entry's busy flag. If no entry is ready, issue_valid=0 and the bundle holds its previous values.
- Flush: at the edge, clear all busy flags and issue_valid. A dispatch in the same cycle is dropped. CDB updates in that cycle are discarded.
- rdy_in=0: no register changes, including flush and dispatch. Outputs hold.
- Reset (rst_in=0, async): all busy flags 0, issue_valid 0, all issue_* 0, rs_full 0.

## Timing
- Dispatch sampled at edge k with both operands ready → entry ready in cycle k+1 → issue_valid=1 after edge k+1. Minimum dispatch-to-issue latency is 2 edges.
- CDB match at edge k → issue no earlier than edge k+1.
- Throughput: one issue per cycle. Dispatch and issue may occur in the same cycle.
- rs_full reflects the state after the last edge. Dispatch in the cycle rs_full falls is legal.
- issue_valid is a one-cycle pulse per issued instruction. The ALU has no back-pressure.
- Reset asserted mid-operation clears state immediately. The first dispatch is accepted at the first edge after deassertion.

## Test plan
- Reset then dispatch ADD (vj=5, vk=7, both ready, dest=3) at edge 1 → issue_valid=1 after edge 2, with issue_rs1=5, issue_rs2=7, issue_dest=3. issue_valid=0 after edge 3.
- Dispatch SUB with qj_busy, qj=6. Pulse cdb1 (tag 6, value 0x10) two cycles later → issue one edge after the CDB edge, with issue_rs1=0x10.
- Dispatch with qj=2 while cdb0 broadcasts tag 2, value 9, in the same cycle → entry stored ready. Issue follows after the next edge with rs1=9.
- Fill 8 entries, all waiting on tag 1 → rs_full=1 and a 9th dispatch is dropped. Broadcast tag 1 → entries 0..7 issue in index order on 8 consecutive edges. rs_full drops after the first issue.
- With 3 waiting entries, assert flush_in together with disp_valid → after the edge, all entries are free and issue_valid=0. A later CDB for the old tags causes no issue.
- Hold rdy_in=0 for 3 cycles during dispatch and a CDB broadcast → no state change and outputs hold. Resume with rdy_in=1 → normal behaviour.
